pwm_array: RTL and testbench

PWM_ARRAY -- requirements
Module: pwm_array

---
 rtl/pwm_array_pkg.sv | 11 +
 rtl/pwm_channel.sv | 34 +++
 rtl/pwm_array.sv | 98 +++++++++
 tb/tb_pwm_array.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_array_pkg.sv
// Shared constants for the multi-channel PWM generator: mode encoding and
// default sizing.
package pwm_array_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int DEF_WIDTH    = 10;
  localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, compare against the shared counter,
// polarity inversion and the registered output.
module pwm_channel
  import pwm_array_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             xfer,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty_pend,
  input  logic             pol,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_act;
  logic             raw_p0;

  assign raw_p0 = (cnt < duty_act);

  // stage p0 -> output flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (xfer) duty_act <= duty_pend;
      pwm <= en ? (raw_p0 ^ pol) : pol;
    end
  end

endmodule

// File: rtl/pwm_array.sv
// Multi-channel PWM with one shared edge/center-aligned counter and
// double-buffered period/duty registers transferred at the period boundary.
module pwm_array
  import pwm_array_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic [CHANNELS-1:0]       pol,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      cycle_start
);

  localparam logic [0:0]       DIR_UP   = 1'b0;
  localparam logic [0:0]       DIR_DOWN = 1'b1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]          cnt;
  logic [0:0]                dir;
  logic                      mode_act;
  logic [WIDTH-1:0]          period_act;
  logic [WIDTH-1:0]          period_pend;
  logic [CHANNELS*WIDTH-1:0] duty_pend;
  logic                      pend;
  logic                      boundary;
  logic                      xfer;
  logic [WIDTH-1:0]          period_eff;

  // While disabled every cycle behaves as a boundary so pending values land.
  assign boundary   = !en || (cnt == '0);
  assign xfer       = boundary && pend;
  assign period_eff = xfer ? period_pend : period_act;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      dir         <= DIR_UP;
      mode_act    <= MODE_EDGE;
      period_act  <= '1;
      period_pend <= '0;
      duty_pend   <= '0;
      pend        <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      if (xfer) period_act <= period_pend;
      // A load on the boundary re-arms pend after the older values transfer.
      if (load) begin
        period_pend <= period_in;
        duty_pend   <= duty_in;
        pend        <= 1'b1;
      end else if (xfer) begin
        pend <= 1'b0;
      end
      cycle_start <= en && (cnt == '0);
      if (!en) begin
        cnt      <= '0;
        dir      <= DIR_UP;
        mode_act <= mode;
      end else if (boundary) begin
        mode_act <= mode;
        dir      <= DIR_UP;
        cnt      <= (period_eff == '0) ? '0 : ONE;
      end else if (mode_act == MODE_EDGE) begin
        cnt <= (cnt >= period_act) ? '0 : cnt + ONE;
      end else if (dir == DIR_UP) begin
        if (cnt >= period_act) begin
          cnt <= cnt - ONE;
          dir <= DIR_DOWN;
        end else begin
          cnt <= cnt + ONE;
        end
      end else begin
        cnt <= cnt - ONE;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .xfer      (xfer),
      .cnt       (cnt),
      .duty_pend (duty_pend[i*WIDTH +: WIDTH]),
      .pol       (pol[i]),
      .pwm       (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_array.sv
// Scoreboard bench for pwm_array: a phase-based reference model queues the
// expected outputs of every cycle, plus directed per-period duty counts.
module tb_pwm_array;

  localparam int W  = 8;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, mode, load;
  logic [W-1:0]  period_in;
  logic [CH*W-1:0] duty_in;
  logic [CH-1:0] pol;
  logic [CH-1:0] pwm;
  logic          cycle_start;

  pwm_array #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .load        (load),
    .period_in   (period_in),
    .duty_in     (duty_in),
    .pol         (pol),
    .pwm         (pwm),
    .cycle_start (cycle_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] pwm;
    logic          cs;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: position within the period, counter derived from it.
  int m_pos, m_p, m_mode, m_pend, m_pp;
  int m_d[CH];
  int m_pd[CH];

  logic [CH-1:0] last_pwm;
  logic          last_cs;
  int            cur_period;
  int            hi[CH];
  int            n_cs;
  int            cs_at0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    logic [W-1:0] b0, b1, b2, b3;
    b0 = W'(d0); b1 = W'(d1); b2 = W'(d2); b3 = W'(d3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic int m_len();
    if (m_mode == 0) return m_p + 1;
    return (m_p == 0) ? 1 : 2 * m_p;
  endfunction

  function automatic int m_cnt();
    if (m_mode == 0) return m_pos;
    return (m_pos <= m_p) ? m_pos : 2 * m_p - m_pos;
  endfunction

  task automatic model_step();
    exp_t e;
    int   c;
    e.pwm = '0;
    e.cs  = 1'b0;
    if (!rst_n) begin
      m_pos = 0; m_p = (1 << W) - 1; m_mode = 0; m_pend = 0; m_pp = 0;
      for (int i = 0; i < CH; i++) begin m_d[i] = 0; m_pd[i] = 0; end
    end else begin
      c = m_cnt();
      for (int i = 0; i < CH; i++)
        e.pwm[i] = en ? ((c < m_d[i]) ^ pol[i]) : pol[i];
      e.cs = en && (m_pos == 0);
      if (!en || m_pos == 0) begin
        if (m_pend != 0) begin
          m_p = m_pp;
          for (int i = 0; i < CH; i++) m_d[i] = m_pd[i];
          m_pend = 0;
        end
        m_mode = int'(mode);
      end
      if (load) begin
        m_pp = int'(period_in);
        for (int i = 0; i < CH; i++) m_pd[i] = int'(duty_in[i*W +: W]);
        m_pend = 1;
      end
      m_pos = en ? (m_pos + 1) % m_len() : 0;
    end
    sb_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    last_pwm = pwm;
    last_cs  = cycle_start;
    check("sb_depth", sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("pwm", pwm, e.pwm);
      check("cycle_start", cycle_start, e.cs);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_cs(input int budget, output int waited);
    waited = 0;
    do begin
      cycle();
      waited++;
    end while (!last_cs && waited < budget);
    if (!last_cs) check("wait_cs_timeout", 0, 1);
  endtask

  // Leaves the bench so that the next driven cycle is a boundary (cnt==0).
  task automatic sync_period(input int len);
    int w;
    wait_cs(600, w);
    run(len - 1);
  endtask

  task automatic count_period(input int n, input int k1, input int d1, input int k2, input int d2);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    n_cs = 0;
    cs_at0 = 0;
    for (int k = 0; k < n; k++) begin
      load = 1'b0;
      if (k == k1) begin load = 1'b1; period_in = W'(cur_period); duty_in = pack(d1, d1, d1, d1); end
      if (k == k2) begin load = 1'b1; period_in = W'(cur_period); duty_in = pack(d2, d2, d2, d2); end
      cycle();
      for (int i = 0; i < CH; i++) hi[i] += int'(last_pwm[i]);
      n_cs += int'(last_cs);
      if (k == 0) cs_at0 = int'(last_cs);
    end
    load = 1'b0;
  endtask

  task automatic check_hi(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_ch0"}, hi[0], e0);
    check({tag, "_ch1"}, hi[1], e1);
    check({tag, "_ch2"}, hi[2], e2);
    check({tag, "_ch3"}, hi[3], e3);
  endtask

  initial begin
    int g;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0;
    period_in = '0; duty_in = '0; pol = '0;
    run(2);
    check("rst_pwm", last_pwm, 0);
    check("rst_cs", last_cs, 0);
    rst_n = 1'b1;

    // Edge mode, period 9, duties {0,3,10,255}
    cur_period = 9;
    period_in = 8'd9; duty_in = pack(0, 3, 10, 255); load = 1'b1;
    cycle();
    load = 1'b0;
    en = 1'b1;
    sync_period(10);
    count_period(10, -1, 0, -1, 0);
    check_hi("edge9", 0, 3, 10, 10);
    check("edge9_ncs", n_cs, 1);
    check("edge9_cs0", cs_at0, 1);

    // Center mode, period 8, duty 4: cnt<4 over 0..8..1 is high 2*4-1 clocks
    cur_period = 8;
    mode = 1'b1; period_in = 8'd8; duty_in = pack(4, 4, 4, 4); load = 1'b1;
    cycle();
    load = 1'b0;
    wait_cs(600, g);
    wait_cs(600, g);
    check("center_gap", g, 16);
    run(15);
    count_period(16, -1, 0, -1, 0);
    check_hi("center8", 7, 7, 7, 7);
    check("center_ncs", n_cs, 1);
    check("center_cs0", cs_at0, 1);

    // Back to edge, duty 6; mid-period load of duty 2
    cur_period = 9;
    mode = 1'b0; period_in = 8'd9; duty_in = pack(6, 6, 6, 6); load = 1'b1;
    cycle();
    load = 1'b0;
    sync_period(10);
    sync_period(10);
    count_period(10, 3, 2, -1, 0);
    check_hi("mid_old", 6, 6, 6, 6);
    count_period(10, -1, 0, -1, 0);
    check_hi("mid_new", 2, 2, 2, 2);
    check("mid_new_cs0", cs_at0, 1);

    // Two loads before a boundary, then a load on the boundary cycle
    count_period(10, 2, 5, 5, 7);
    check_hi("two_cur", 2, 2, 2, 2);
    count_period(10, -1, 0, -1, 0);
    check_hi("two_last", 7, 7, 7, 7);
    count_period(10, 0, 1, -1, 0);
    check_hi("bnd_same", 7, 7, 7, 7);
    count_period(10, -1, 0, -1, 0);
    check_hi("bnd_next", 1, 1, 1, 1);

    // Enable dropped mid-period with polarity 1010, then re-enabled
    pol = 4'b1010;
    run(4);
    en = 1'b0;
    cycle();
    check("en_off_pwm", last_pwm, 4'b1010);
    check("en_off_cs", last_cs, 0);
    run(3);
    en = 1'b1;
    count_period(10, -1, 0, -1, 0);
    check("reen_cs0", cs_at0, 1);
    check("reen_ncs", n_cs, 1);
    check_hi("reen", 1, 9, 1, 9);

    // Reset for one cycle mid-period
    pol = 4'b0000;
    run(3);
    rst_n = 1'b0;
    cycle();
    check("rst_mid_pwm", last_pwm, 0);
    check("rst_mid_cs", last_cs, 0);
    rst_n = 1'b1;
    run(20);
    check("post_rst_pwm", last_pwm, 0);
    pol = 4'b1111;
    run(3);
    check("post_rst_pol", last_pwm, 4'b1111);
    pol = 4'b0000;

    // Period 0: counter parked at 0, cycle_start every cycle
    cur_period = 0;
    en = 1'b0; period_in = 8'd0; duty_in = pack(0, 1, 0, 5); load = 1'b1;
    cycle();
    load = 1'b0;
    cycle();
    en = 1'b1;
    count_period(5, -1, 0, -1, 0);
    check("p0_ncs", n_cs, 5);
    check_hi("p0", 0, 5, 0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
